// File: rtl/minibyte_demux_8x.sv
// Registered 1->8 demultiplexer with valid/ready handshake, one word in flight.
// Optional lane-accept timeout enabled by defining MINIBYTE_DEMUX_TIMEOUT_EN.
module minibyte_demux_8x #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [2:0]         sel_in,
  input  logic               valid_in,
  output logic               ready_out,
  output logic [8*WIDTH-1:0] lane_data_out,
  output logic [7:0]         lane_valid_out,
  input  logic [7:0]         lane_ready_in,
  output logic               err_out
);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t       state, state_nxt;
  logic [2:0]   sel_q;
  logic         take;
  logic         accept;
  logic         expire;

  assign take   = valid_in && (state == IDLE);
  assign accept = (state == OFFER) && lane_ready_in[sel_q];

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready_out = 1'b0;
    case (state)
      IDLE: begin
        ready_out = 1'b1;
        if (valid_in) state_nxt = OFFER;
      end
      OFFER: begin
        if (accept || expire) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // lane_valid_out is decoded from registered state only, so it drops on the accept edge
  always_comb begin
    lane_valid_out = '0;
    if (state == OFFER) lane_valid_out[sel_q] = 1'b1;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sel_q         <= '0;
      lane_data_out <= '0;
    end else if (take) begin
      sel_q <= sel_in;
      for (int unsigned k = 0; k < 8; k++) begin
        if (sel_in == 3'(k)) lane_data_out[k*WIDTH +: WIDTH] <= data_in;
      end
    end
  end

`ifdef MINIBYTE_DEMUX_TIMEOUT_EN
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] wait_cnt;
  logic       err_q;

  // expiry fires on the edge ending the TIMEOUT_CYCLES-th offer cycle; accept has priority
  assign expire  = (state == OFFER) && !lane_ready_in[sel_q] && (wait_cnt == CNT_LAST);
  assign err_out = err_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (take)                         wait_cnt <= '0;
      else if (state == OFFER && !accept) wait_cnt <= wait_cnt + 8'd1;
      if (expire) err_q <= 1'b1;
    end
  end
`else
  assign expire  = 1'b0;
  assign err_out = 1'b0;
`endif

endmodule
